// File: rtl/dmux8_router.sv
// dmux8_router: registered valid/ready 8-way demultiplexer.
// One word in per cycle, eight single-entry output slots.
module dmux8_router #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               rr_mode,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [2:0]         rr_ptr,
    output logic [CNT_W-1:0]   xfer_count,
    output logic               busy
);

    logic [WIDTH-1:0] slot_q [8];
    logic [7:0]       valid_q;
    logic [2:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       dest;
    logic             accept;

    assign dest     = rr_mode ? ptr_q : in_sel;
    // A full slot can still take a word on the edge its consumer pops it.
    assign in_ready = ~valid_q[dest] | out_ready[dest];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (accept && dest == 3'(i)) begin
                    slot_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                if (rr_mode) begin
                    ptr_q <= ptr_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < 8; i++) begin
            out_data[i*WIDTH +: WIDTH] = slot_q[i];
        end
    end

    assign out_valid  = valid_q;
    assign rr_ptr     = ptr_q;
    assign xfer_count = cnt_q;
    assign busy       = |valid_q;

endmodule

// File: tb/tb_dmux8_router.sv
// tb_dmux8_router: directed and random stimulus for dmux8_router,
// checked against a slot-array reference model.
module tb_dmux8_router;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [2:0]         in_sel;
    logic               rr_mode;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready;
    logic [8*WIDTH-1:0] out_data;
    logic [2:0]         rr_ptr;
    logic [CNT_W-1:0]   xfer_count;
    logic               busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit       mv [8];
    int       md [8];
    int       mptr;
    int       mcnt;
    bit       last_acc;

    dmux8_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .rr_mode(rr_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .rr_ptr(rr_ptr),
        .xfer_count(xfer_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 0;
            md[i] = 0;
        end
        mptr = 0;
        mcnt = 0;
    endtask

    task automatic check_state(input string tag);
        logic [7:0]   ev;
        logic [127:0] ed;
        ev = '0;
        ed = '0;
        for (int i = 0; i < 8; i++) begin
            ev[i] = mv[i];
            ed[i*WIDTH +: WIDTH] = md[i][WIDTH-1:0];
        end
        chk({tag, ".valid"}, 128'(out_valid), 128'(ev));
        chk({tag, ".data"}, 128'(out_data), ed);
        chk({tag, ".ptr"}, 128'(rr_ptr), 128'(mptr));
        chk({tag, ".cnt"}, 128'(xfer_count), 128'(mcnt));
        chk({tag, ".busy"}, 128'(busy), 128'(ev != 0));
    endtask

    // Inputs are set by the caller shortly after a rising edge.
    task automatic cycle(input string tag);
        int  d;
        bit  rdy;
        bit  acc;
        @(negedge clk);
        d   = rr_mode ? mptr : int'(in_sel);
        rdy = !mv[d] || out_ready[d];
        acc = in_valid && rdy;
        chk({tag, ".rdy"}, 128'(in_ready), 128'(rdy));
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (acc && d == i) begin
                mv[i] = 1;
                md[i] = int'(in_data);
            end else if (out_ready[i]) begin
                mv[i] = 0;
            end
        end
        if (acc) begin
            mcnt = (mcnt + 1) % 256;
            if (rr_mode) mptr = (mptr + 1) % 8;
        end
        last_acc = acc;
        #1;
        check_state(tag);
    endtask

    task automatic send(input bit v, input int sel, input int data,
                        input bit rr, input logic [7:0] ordy,
                        input string tag);
        in_valid  = v;
        in_sel    = 3'(sel);
        in_data   = WIDTH'(data);
        rr_mode   = rr;
        out_ready = ordy;
        cycle(tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state("rst_async");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        rr_mode   = 1'b0;
        out_ready = '0;
        model_reset();
        #12;
        check_state("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // select-mode fill of all eight slots
        for (int i = 0; i < 8; i++) begin
            send(1, i, 'h0A00 + i, 0, 8'h00, "fill");
        end
        chk("fill.full", 128'(out_valid), 128'hFF);
        chk("fill.cnt8", 128'(xfer_count), 128'd8);
        send(1, 3, 'h1234, 0, 8'h00, "ninth");
        chk("ninth.rejected", 128'(last_acc), 128'd0);

        // pass-through on a full slot, then streaming
        send(1, 4, 'hBEEF, 0, 8'h10, "pass");
        chk("pass.slot4", 128'(out_data[4*WIDTH +: WIDTH]), 128'hBEEF);
        for (int i = 0; i < 6; i++) begin
            send(1, 4, 'h5500 + i, 0, 8'h10, "stream");
            chk("stream.acc", 128'(last_acc), 128'd1);
        end

        // asynchronous reset with slots 2 and 5 full
        do_reset();
        send(1, 2, 'h2222, 0, 8'h00, "pre2");
        send(1, 5, 'h5555, 0, 8'h00, "pre5");
        do_reset();
        in_valid = 1'b0;
        out_ready = 8'h00;
        #1;
        chk("post_rst.rdy", 128'(in_ready), 128'd1);

        // round-robin wrap, in_sel noise ignored
        for (int i = 1; i <= 10; i++) begin
            send(1, int'($urandom_range(7)), i, 1, 8'hFF, "rr");
        end
        chk("rr.ptr2", 128'(rr_ptr), 128'd2);

        // round-robin stall on a full slot 6
        for (int i = 0; i < 4; i++) begin
            send(1, 0, 'h3000 + i, 1, 8'h00, "rrfill");
        end
        send(1, 6, 'h6666, 0, 8'h00, "fill6");
        chk("stall.pre_ptr", 128'(rr_ptr), 128'd6);
        for (int i = 0; i < 3; i++) begin
            send(1, 0, 'h7777, 1, 8'h00, "stall");
            chk("stall.noacc", 128'(last_acc), 128'd0);
        end
        send(1, 0, 'h7777, 1, 8'h40, "unstall");
        chk("unstall.ptr7", 128'(rr_ptr), 128'd7);

        // counter wrap with mid-stream mode switch
        do_reset();
        n = 0;
        for (int i = 0; i < 600 && n < 256; i++) begin
            send(1, int'($urandom_range(7)), int'($urandom), n < 100,
                 8'hFF, "wrap");
            if (last_acc) n++;
        end
        chk("wrap.n", 128'(n), 128'd256);
        chk("wrap.cnt0", 128'(xfer_count), 128'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom_range(1)), int'($urandom_range(7)),
                 int'($urandom), 1'($urandom_range(1)),
                 8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
